// File: rtl/pcs_rx_ext.sv
// 1000BASE-X PCS receive FSM with 3-symbol lookahead: EPD detection, carrier extension, RX_ER, statistics.
// A symbol sampled on SUDI edge k reaches the GMII outputs after SUDI edge k+3; SUDI=0 holds pipeline, FSM and outputs.
module pcs_rx_ext #(
   parameter int LEN_W   = 14,
   parameter int MAX_LEN = 1518,
   parameter int CNT_W   = 16,
   parameter bit EXT_EN  = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sync_status,
   input  logic             SUDI,
   input  logic [7:0]       rx_byte,
   input  logic             rx_is_k,
   input  logic             rx_cerr,
   input  logic             rx_even,
   output logic [7:0]       RXD,
   output logic             RX_DV,
   output logic             RX_ER,
   output logic             RX_CLK,
   output logic [LEN_W-1:0] rx_len,
   output logic             len_err,
   output logic [CNT_W-1:0] frame_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] fc_cnt
);
   localparam logic [7:0]     K28_5 = 8'hBC;
   localparam logic [7:0]     K_S   = 8'hFB;
   localparam logic [7:0]     K_T   = 8'hFD;
   localparam logic [7:0]     K_R   = 8'hF7;
   localparam logic [7:0]     K_V   = 8'hFE;
   localparam logic [LEN_W:0] MAX_L = (LEN_W+1)'(MAX_LEN);

   typedef struct packed {
      logic [7:0] dat;
      logic       k;
      logic       cerr;
      logic       even;
      logic       vld;
   } sym_t;

   typedef enum logic [2:0] {
      WAIT_FOR_K, RX_K, IDLE_D, RECEIVE, FALSE_CARRIER, TRI_RRI
   } state_t;

   sym_t             s2, s1, s0;
   state_t           state, state_n;
   logic             ext_flag, err_seen;
   logic [LEN_W-1:0] len_cnt;
   logic             step, t_r, err_sym;
   logic [7:0]       rxd_n;
   logic             dv_n, er_n;
   logic             len_clr, len_inc, frm_end, fc_inc, err_inc, ext_set, ext_clr;

   function automatic logic is_kc(input sym_t s, input logic [7:0] c);
      return s.vld && s.k && !s.cerr && (s.dat == c);
   endfunction

   function automatic logic is_d(input sym_t s);
      return s.vld && !s.k && !s.cerr;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign RX_CLK  = clk;
   assign step    = SUDI && s0.vld;
   assign t_r     = is_kc(s0, K_T) && is_kc(s1, K_R);
   assign err_sym = s0.cerr || (s0.k && s0.dat == K_V);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2 <= '0;
         s1 <= '0;
         s0 <= '0;
      end else if (SUDI) begin
         s0 <= s1;
         s1 <= s2;
         s2 <= {rx_byte, rx_is_k, rx_cerr, rx_even, 1'b1};
      end
   end

   always_comb begin
      state_n = state;
      rxd_n   = '0;
      dv_n    = 1'b0;
      er_n    = 1'b0;
      len_clr = 1'b0;
      len_inc = 1'b0;
      frm_end = 1'b0;
      fc_inc  = 1'b0;
      err_inc = 1'b0;
      ext_set = 1'b0;
      ext_clr = 1'b0;
      case (state)
         WAIT_FOR_K: begin
            if (is_kc(s0, K28_5) && s0.even) state_n = RX_K;
         end
         RX_K: begin
            state_n = is_d(s0) ? IDLE_D : WAIT_FOR_K;
         end
         IDLE_D: begin
            if (is_kc(s0, K28_5)) begin
               state_n = RX_K;
            end else if (is_kc(s0, K_S)) begin
               state_n = RECEIVE;
               rxd_n   = 8'h55;
               dv_n    = 1'b1;
               len_clr = 1'b1;
            end else begin
               state_n = FALSE_CARRIER;
               rxd_n   = 8'h0E;
               er_n    = 1'b1;
               fc_inc  = 1'b1;
            end
         end
         FALSE_CARRIER: begin
            if (is_kc(s0, K28_5)) begin
               state_n = RX_K;
            end else begin
               rxd_n = 8'h0E;
               er_n  = 1'b1;
            end
         end
         RECEIVE: begin
            if (t_r && is_kc(s2, K28_5)) begin
               state_n = TRI_RRI;
               frm_end = 1'b1;
               ext_clr = 1'b1;
            end else if (t_r && is_kc(s2, K_R)) begin
               state_n = TRI_RRI;
               frm_end = 1'b1;
               ext_set = EXT_EN;
            end else if (is_kc(s0, K28_5) && is_d(s1)) begin
               // early end: frame cut by idle without /T/
               state_n = RX_K;
               er_n    = 1'b1;
               err_inc = 1'b1;
            end else if (err_sym || (is_kc(s0, K_T) && !is_kc(s1, K_R))) begin
               rxd_n   = s0.dat;
               dv_n    = 1'b1;
               er_n    = 1'b1;
               err_inc = 1'b1;
            end else if (is_d(s0)) begin
               rxd_n   = s0.dat;
               dv_n    = 1'b1;
               len_inc = 1'b1;
            end
         end
         TRI_RRI: begin
            if (is_kc(s0, K_T)) begin
               state_n = TRI_RRI;
            end else if (is_kc(s0, K_R)) begin
               if (ext_flag && is_kc(s1, K_R)) begin
                  rxd_n = 8'h0F;
                  er_n  = 1'b1;
               end
            end else if (is_kc(s0, K28_5)) begin
               state_n = RX_K;
               ext_clr = 1'b1;
            end else begin
               state_n = WAIT_FOR_K;
               ext_clr = 1'b1;
            end
         end
         default: state_n = WAIT_FOR_K;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= WAIT_FOR_K;
         RXD       <= '0;
         RX_DV     <= 1'b0;
         RX_ER     <= 1'b0;
         ext_flag  <= 1'b0;
         err_seen  <= 1'b0;
         len_cnt   <= '0;
         rx_len    <= '0;
         len_err   <= 1'b0;
         frame_cnt <= '0;
         err_cnt   <= '0;
         fc_cnt    <= '0;
      end else if (!sync_status) begin
         state    <= WAIT_FOR_K;
         RXD      <= '0;
         RX_DV    <= 1'b0;
         RX_ER    <= 1'b0;
         ext_flag <= 1'b0;
      end else if (step) begin
         state <= state_n;
         RXD   <= rxd_n;
         RX_DV <= dv_n;
         RX_ER <= er_n;
         if (ext_set) ext_flag <= 1'b1;
         else if (ext_clr) ext_flag <= 1'b0;
         if (len_clr) begin
            len_cnt  <= '0;
            err_seen <= 1'b0;
         end else if (len_inc && !(&len_cnt)) begin
            len_cnt <= len_cnt + 1'b1;
         end
         if (frm_end) begin
            rx_len    <= len_cnt;
            len_err   <= ({1'b0, len_cnt} > MAX_L);
            frame_cnt <= sat_inc(frame_cnt);
         end
         if (fc_inc) fc_cnt <= sat_inc(fc_cnt);
         // errored frames are counted once, however many bad octets they carry
         if (err_inc && !err_seen) begin
            err_cnt  <= sat_inc(err_cnt);
            err_seen <= 1'b1;
         end
      end
   end
endmodule
